// File: rtl/qpsk_modulator.sv
// QPSK transmitter: symbol FIFO, per-symbol hold FSM, NCO plus cosine LUT, 2-stage output pipe.
// Optional macro QPSK_TX_UNDERRUN_CNT_EN adds a saturating underrun_cnt output.
module qpsk_modulator #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned OUT_W      = 16,
  parameter int unsigned LUT_AW     = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [31:0]             fcw,
  input  logic [15:0]             sps,
  input  logic [1:0]              sym_in,
  input  logic                    sym_valid,
  output logic                    sym_ready,
  output logic signed [OUT_W-1:0] dac_out,
  output logic                    dac_valid,
  output logic                    busy,
  output logic                    underrun
`ifdef QPSK_TX_UNDERRUN_CNT_EN
  ,
  output logic [15:0]             underrun_cnt
`endif
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned ACC_W = 32;
  localparam int unsigned LUT_N = 2 ** LUT_AW;
  localparam real         TWO_PI = 6.283185307179586;
  localparam real         AMP    = real'((64'd1 << (OUT_W - 1)) - 64'd1);

  typedef enum logic {ST_IDLE, ST_SEND} state_t;

  // Full-wave cosine table, rounded to nearest at elaboration
  logic signed [OUT_W-1:0] lut_rom [LUT_N];
  for (genvar k = 0; k < LUT_N; k++) begin : g_lut
    localparam real COS_R = AMP * $cos(TWO_PI * real'(k) / real'(LUT_N));
    localparam int  COS_I = (COS_R >= 0.0) ? $rtoi(COS_R + 0.5) : -$rtoi(0.5 - COS_R);
    assign lut_rom[k] = OUT_W'(COS_I);
  end

  logic [1:0]       fifo_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             fifo_full_c;
  logic             fifo_empty_c;
  logic             push_c;
  logic             pop_c;

  state_t           state_q;
  logic [1:0]       cur_sym_q;
  logic [15:0]      sps_l_q;
  logic [15:0]      cnt_q;
  logic [15:0]      sps_eff_c;
  logic             last_c;
  logic             und_set_c;
  logic             underrun_q;

  logic [ACC_W-1:0]        acc_q;
  logic [ACC_W-1:0]        acc_d;
  logic [LUT_AW-1:0]       sym_off_c;
  logic [LUT_AW-1:0]       phase_c;
  logic [LUT_AW-1:0]       addr_q;
  logic                    s1_valid_q;
  logic signed [OUT_W-1:0] dac_out_q;
  logic                    dac_valid_q;

  assign fifo_full_c  = (count_q == CNT_W'(FIFO_DEPTH));
  assign fifo_empty_c = (count_q == '0);
  assign sym_ready    = !fifo_full_c;
  assign push_c       = sym_valid && !fifo_full_c;

  // A symbol boundary is either an idle start or the last sample of the held symbol
  assign sps_eff_c = (sps == 16'd0) ? 16'd1 : sps;
  assign last_c    = (state_q == ST_SEND) && (cnt_q == sps_l_q - 16'd1);
  assign pop_c     = enable && !fifo_empty_c && ((state_q == ST_IDLE) || last_c);
  assign und_set_c = last_c && enable && fifo_empty_c;

  // Symbol storage carries no reset; occupancy is tracked by the pointers and count
  always_ff @(posedge clk) begin
    if (push_c) begin
      fifo_q[wr_ptr_q] <= sym_in;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_c)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push_c, pop_c})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Symbol hold FSM; sps is relatched only at a boundary
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      cur_sym_q  <= 2'b00;
      sps_l_q    <= 16'd1;
      cnt_q      <= 16'd0;
      underrun_q <= 1'b0;
    end else begin
      underrun_q <= und_set_c;
      case (state_q)
        ST_IDLE: begin
          if (pop_c) begin
            state_q   <= ST_SEND;
            cur_sym_q <= fifo_q[rd_ptr_q];
            sps_l_q   <= sps_eff_c;
            cnt_q     <= 16'd0;
          end
        end
        ST_SEND: begin
          if (last_c) begin
            cnt_q <= 16'd0;
            if (pop_c) begin
              cur_sym_q <= fifo_q[rd_ptr_q];
              sps_l_q   <= sps_eff_c;
            end else begin
              state_q <= ST_IDLE;
            end
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
      endcase
    end
  end

  always_comb begin
    acc_d = acc_q;
    if (enable) begin
      acc_d = acc_q + fcw;
    end else if (state_q == ST_IDLE) begin
      acc_d = '0;
    end
  end

  // Symbol offset {sym, 1, 0...} lands on the 45/135/225/315 degree points
  assign sym_off_c = LUT_AW'({cur_sym_q, 1'b1}) << (LUT_AW - 3);
  assign phase_c   = acc_q[ACC_W-1 -: LUT_AW] + sym_off_c;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q       <= '0;
      addr_q      <= '0;
      s1_valid_q  <= 1'b0;
      dac_out_q   <= '0;
      dac_valid_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      addr_q      <= phase_c;
      s1_valid_q  <= (state_q == ST_SEND);
      dac_out_q   <= s1_valid_q ? lut_rom[addr_q] : '0;
      dac_valid_q <= s1_valid_q;
    end
  end

  assign dac_out   = dac_out_q;
  assign dac_valid = dac_valid_q;
  assign busy      = (state_q == ST_SEND);
  assign underrun  = underrun_q;

`ifdef QPSK_TX_UNDERRUN_CNT_EN
  logic [15:0] und_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      und_cnt_q <= 16'd0;
    end else if (und_set_c && (und_cnt_q != 16'hFFFF)) begin
      und_cnt_q <= und_cnt_q + 16'd1;
    end
  end

  assign underrun_cnt = und_cnt_q;
`endif

endmodule

// File: tb/tb_qpsk_modulator.sv
// Directed bench for qpsk_modulator: queue-based transmitter model checked every cycle,
// plus literal sample sequences for the key scenarios.
`timescale 1ns/1ps
module tb_qpsk_modulator;

  localparam int DEPTH = 4;
  localparam int P     = 23170;
  localparam int N     = -23170;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               enable = 1'b0;
  logic [31:0]        fcw = 32'd0;
  logic [15:0]        sps = 16'd1;
  logic [1:0]         sym_in = 2'b00;
  logic               sym_valid = 1'b0;
  logic               sym_ready;
  logic signed [15:0] dac_out;
  logic               dac_valid;
  logic               busy;
  logic               underrun;
`ifdef QPSK_TX_UNDERRUN_CNT_EN
  logic [15:0]        underrun_cnt;
`endif

  qpsk_modulator #(.FIFO_DEPTH(4), .OUT_W(16), .LUT_AW(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .fcw       (fcw),
    .sps       (sps),
    .sym_in    (sym_in),
    .sym_valid (sym_valid),
    .sym_ready (sym_ready),
    .dac_out   (dac_out),
    .dac_valid (dac_valid),
    .busy      (busy),
    .underrun  (underrun)
`ifdef QPSK_TX_UNDERRUN_CNT_EN
    ,
    .underrun_cnt (underrun_cnt)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference cosine straight from the math library
  function automatic int cos_ref(input int idx);
    real r;
    r = 32767.0 * $cos(6.283185307179586 * real'(idx % 256) / 256.0);
    return int'($floor(r + 0.5));
  endfunction

  // Transmitter model: queue of pending symbols, samples left in the symbol on air
  int        mq[$];
  bit        m_on;
  int        m_cur;
  int        m_left;
  bit [31:0] m_acc;
  int        p1_val;
  bit        p1_v;
  int        e_dac;
  bit        e_valid;
  bit        e_under;
  int        m_und_total;
  bit        was_on;
  int        sz0;
  bit        do_push;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mq.delete();
      m_on = 0; m_cur = 0; m_left = 0; m_acc = 0;
      p1_val = 0; p1_v = 0; e_dac = 0; e_valid = 0; e_under = 0;
      m_und_total = 0;
    end else begin
      was_on  = m_on;
      sz0     = mq.size();
      do_push = sym_valid && (sz0 < DEPTH);
      e_dac   = p1_val;
      e_valid = p1_v;
      p1_v    = m_on;
      p1_val  = m_on ? cos_ref(int'(m_acc[31:24]) + 64 * m_cur + 32) : 0;
      e_under = 0;
      if (m_on) begin
        if (m_left > 1) begin
          m_left--;
        end else if (enable && sz0 > 0) begin
          m_cur  = mq.pop_front();
          m_left = (sps == 0) ? 1 : int'(sps);
        end else begin
          m_on = 0;
          if (enable) begin
            e_under = 1;
            m_und_total++;
          end
        end
      end else if (enable && sz0 > 0) begin
        m_cur  = mq.pop_front();
        m_left = (sps == 0) ? 1 : int'(sps);
        m_on   = 1;
      end
      if (do_push) mq.push_back(int'(sym_in));
      if (enable) m_acc = m_acc + fcw;
      else if (!was_on) m_acc = 0;
    end
  end

  bit chk = 0;

  always @(negedge clk) begin
    if (reset && chk) begin
      check("dac_out", longint'(dac_out), longint'(e_dac));
      check("dac_valid", longint'(dac_valid), longint'(e_valid));
      check("busy", longint'(busy), longint'(m_on));
      check("sym_ready", longint'(sym_ready), longint'(mq.size() < DEPTH));
      check("underrun", longint'(underrun), longint'(e_under));
`ifdef QPSK_TX_UNDERRUN_CNT_EN
      check("underrun_cnt", longint'(underrun_cnt), longint'(m_und_total));
`endif
    end
  end

  // Capture of transmitted samples and events for the literal checks
  int cap[$];
  int und_seen;
  int runs;
  int accepted;
  bit prev_v;

  always @(negedge clk) begin
    if (reset) begin
      if (dac_valid) cap.push_back(int'(dac_out));
      if (dac_valid && !prev_v) runs++;
      prev_v = dac_valid;
      if (underrun) und_seen++;
      if (sym_valid && sym_ready) accepted++;
    end else begin
      prev_v = 0;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input int s);
    sym_in    = 2'(s);
    sym_valid = 1'b1;
    tick();
    sym_valid = 1'b0;
  endtask

  task automatic clear_mon();
    cap.delete();
    und_seen = 0;
    runs     = 0;
    accepted = 0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    tick(2);
    while ((busy || dac_valid) && n < 500) begin
      tick();
      n++;
    end
    total++;
    if (n >= 500) begin
      bad++;
      $display("FAIL %s_timeout: busy=%0b dac_valid=%0b expected 0", name, busy, dac_valid);
    end
    tick(2);
  endtask

  task automatic check_seq(input string name, input int n, input int e[8]);
    check({name, "_len"}, longint'(cap.size()), longint'(n));
    for (int i = 0; i < n; i++) begin
      if (i < cap.size()) check(name, longint'(cap[i]), longint'(e[i]));
    end
  endtask

  int ex[8];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    tick(3);
    check("rst_dac_out", longint'(dac_out), 0);
    check("rst_dac_valid", longint'(dac_valid), 0);
    check("rst_busy", longint'(busy), 0);
    check("rst_underrun", longint'(underrun), 0);
    check("rst_sym_ready", longint'(sym_ready), 1);
    reset = 1'b1;
    chk   = 1;
    tick(2);

    // Single symbol 00 held for 4 clocks, then underrun and silence
    fcw = 32'd0; sps = 16'd4; enable = 1'b1;
    clear_mon();
    push(0);
    wait_done("t1");
    ex = '{P, P, P, P, 0, 0, 0, 0};
    check_seq("t1_seq", 4, ex);
    check("t1_underruns", longint'(und_seen), 1);
    check("t1_idle_dac", longint'(dac_out), 0);
    check("t1_idle_valid", longint'(dac_valid), 0);

    // Four back-to-back symbols, sps=2, one contiguous burst
    sps = 16'd2;
    clear_mon();
    push(0); push(1); push(2); push(3);
    wait_done("t2");
    ex = '{P, P, N, N, N, N, P, P};
    check_seq("t2_seq", 8, ex);
    check("t2_underruns", longint'(und_seen), 1);
    check("t2_bursts", longint'(runs), 1);

    // Fill while disabled, then drain in FIFO order
    enable = 1'b0;
    tick(2);
    clear_mon();
    sym_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      sym_in = 2'(i % 4);
      tick();
    end
    sym_valid = 1'b0;
    check("t3_ready_full", longint'(sym_ready), 0);
    check("t3_accepted", longint'(accepted), 4);
    enable = 1'b1;
    tick();
    check("t3_ready_after_pop", longint'(sym_ready), 1);
    wait_done("t3");
    ex = '{P, P, N, N, N, N, P, P};
    check_seq("t3_seq", 8, ex);
    check("t3_underruns", longint'(und_seen), 1);

    // Quarter-rate carrier: phase advances 90 degrees per clock
    enable = 1'b0;
    fcw = 32'h4000_0000; sps = 16'd8;
    tick(2);
    clear_mon();
    push(0);
    enable = 1'b1;
    wait_done("t4");
    ex = '{N, N, P, P, N, N, P, P};
    check_seq("t4_seq", 8, ex);
    check("t4_underruns", longint'(und_seen), 1);

    // Asynchronous reset in the middle of a symbol
    enable = 1'b0;
    tick(2);
    fcw = 32'd0; sps = 16'd4; enable = 1'b1;
    push(1);
    push(2);
    tick(2);
    check("t5_busy_before", longint'(busy), 1);
    #2;
    reset = 1'b0;
    #1;
    check("t5_rst_dac_out", longint'(dac_out), 0);
    check("t5_rst_dac_valid", longint'(dac_valid), 0);
    check("t5_rst_busy", longint'(busy), 0);
    check("t5_rst_sym_ready", longint'(sym_ready), 1);
    tick();
    reset = 1'b1;
    clear_mon();
    tick(8);
    check("t5_no_tx", longint'(cap.size()), 0);
    check("t5_idle_busy", longint'(busy), 0);

    // Three isolated bursts, then a burst cut short by enable
    sps = 16'd2;
    clear_mon();
    for (int b = 0; b < 3; b++) begin
      push(b);
      wait_done("t6");
    end
    check("t6_underruns", longint'(und_seen), 3);
`ifdef QPSK_TX_UNDERRUN_CNT_EN
    check("t6_cnt3", longint'(underrun_cnt), 3);
`endif
    sps = 16'd4;
    clear_mon();
    push(3);
    tick();
    enable = 1'b0;
    wait_done("t6b");
    check("t6b_underruns", longint'(und_seen), 0);
    check("t6b_samples", longint'(cap.size()), 4);
`ifdef QPSK_TX_UNDERRUN_CNT_EN
    check("t6b_cnt_hold", longint'(underrun_cnt), 3);
`endif

    chk = 0;
    tick(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
